debounce_repeat: RTL and testbench
==================================

# debounce_repeat

Button conditioning stage placed directly downstream of the input synchronizer in the ALU front panel. Takes the already-synchronized button level, rejects contact bounce with a consecutive-sample counter, and produces a clean debounced level plus single-cycle press, release and auto-repeat strobes for the operand-entry and operation-select logic. Holding a button produces one press strobe, then repeat strobes after an initial delay and at a fixed rate until release.

## Interface
- DEBOUNCE_CYCLES, 500_000, consecutive equal samples needed to accept a level change (10 ms at 50 MHz); must be ≥ 2
- REPEAT_DELAY, 25_000_000, HELD cycles from press strobe to first repeat strobe; must be ≥ 2
- REPEAT_RATE, 5_000_000, HELD cycles between subsequent repeat strobes; must be ≥ 2
- clock  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- syncIn  input  1  synchronized button level (already metastability-hardened)
- repeatEn  input  1  1 = auto-repeat enabled; sampled every cycle
- level  output  1  debounced button level
- pressPulse  output  1  one-cycle strobe on accepted rising level
- releasePulse  output  1  one-cycle strobe on accepted falling level
- repeatPulse  output  1  one-cycle auto-repeat strobe
- longHold  output  1  high from first repeat strobe until accepted release

## Operation
- All outputs registered. rst=1 at a clock edge: state IDLE, both counters 0, phase flag 0, every output 0; overrides all other activity, including mid-debounce or mid-repeat.
- Debounce counter dcnt; repeat counter rcnt; phase flag rptPhase (0 = waiting REPEAT_DELAY, 1 = waiting REPEAT_RATE).
- IDLE (level=0): syncIn=1 → PRESS_WAIT, dcnt=1.
- PRESS_WAIT: syncIn=0 → IDLE, dcnt=0, no strobe (glitch rejected). syncIn=1 and dcnt=DEBOUNCE_CYCLES-1 → HELD, level=1, pressPulse=1, rcnt=0, rptPhase=0. Otherwise dcnt+1.
- HELD (level=1): syncIn=0 → RELEASE_WAIT, dcnt=1, rcnt frozen. Else if repeatEn=0: rcnt=0, rptPhase unchanged. Else if rcnt = threshold-1 (threshold = REPEAT_DELAY when rptPhase=0, REPEAT_RATE when 1) → repeatPulse=1, rcnt=0, rptPhase=1, longHold=1. Else rcnt+1.
- RELEASE_WAIT (level=1): syncIn=1 → HELD, no strobe, rcnt resumes from frozen value. syncIn=0 and dcnt=DEBOUNCE_CYCLES-1 → IDLE, level=0, releasePulse=1, longHold=0, rptPhase=0. Otherwise dcnt+1.
- Strobes are never asserted in two consecutive cycles from the same cause; pressPulse, repeatPulse and releasePulse are mutually exclusive in any cycle.
- Counter width: $clog2 of the largest parameter; no wrap-around possible since every counter is cleared at its terminal value.

## Timing
- syncIn first sampled high at edge k and high through edge k+DEBOUNCE_CYCLES-1 → pressPulse and level=1 in the cycle following edge k+DEBOUNCE_CYCLES-1. Release is symmetric.
- First repeatPulse exactly REPEAT_DELAY cycles after pressPulse, then every REPEAT_RATE cycles, extended one cycle per RELEASE_WAIT cycle or repeatEn=0 interval.
- A release glitch shorter than DEBOUNCE_CYCLES leaves level unchanged; a press glitch likewise.
- repeatEn deasserted then reasserted restarts the current phase interval from 0.

## Structure
- Package debounce_pkg: state enum typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and a width function for counter sizing.
- One natural sub-module: hold_counter (loadable terminal-count counter with enable/clear), instantiated for dcnt and rcnt.

## Test plan
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- rst=1 for 2 cycles with syncIn=1 → all outputs 0; after rst=0, pressPulse 4 cycles later, level=1.
- syncIn high 3 cycles then low → no pressPulse, level stays 0; then high 4 cycles → one pressPulse.
- Press, hold 20 cycles after pressPulse, repeatEn=1 → repeatPulse at P+10, P+13, P+16, P+19; longHold=1 from P+10.
- During hold, syncIn low 2 cycles before first repeat → no releasePulse, first repeat shifts to P+12.
- syncIn low 4 cycles after hold → single releasePulse, level=0, longHold=0; new press restarts at REPEAT_DELAY.
- repeatEn=0, hold 30 cycles → zero repeatPulse, longHold=0; assert rst mid-hold → all outputs 0 next cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the button debounce/repeat stage.
// Provides the FSM state enum and the counter width function.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } stateT;

   // Width able to hold (largest parameter - 1).
   function automatic int cntWidth(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable up-counter with clear/enable and a terminal-value compare.
// Ports: clock, rst, clr, load(loadVal), en, termVal -> atTerm.
module hold_counter #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] loadVal,
   input  logic [W-1:0] termVal,
   output logic         atTerm
);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= loadVal;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign atTerm = (count == termVal);

endmodule

// File: rtl/debounce_repeat.sv
// Debounced button level with press, release and auto-repeat strobes.
// Ports: clock, rst, syncIn, repeatEn -> level, pulses, longHold.
module debounce_repeat
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 5_000_000
) (
   input  logic clock,
   input  logic rst,
   input  logic syncIn,
   input  logic repeatEn,
   output logic level,
   output logic pressPulse,
   output logic releasePulse,
   output logic repeatPulse,
   output logic longHold
);

   localparam int W = cntWidth(
      DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

   localparam logic [W-1:0] D_TERM =
      W'(DEBOUNCE_CYCLES - 1);
   localparam logic [W-1:0] DLY_TERM =
      W'(REPEAT_DELAY - 1);
   localparam logic [W-1:0] RATE_TERM =
      W'(REPEAT_RATE - 1);
   localparam logic [W-1:0] ONE = W'(1);

   stateT state, stateN;
   logic  rptPhase, phaseN;
   logic  levelN, pressN, releaseN;
   logic  repeatN, longHoldN;
   logic  dClr, dLoad, dInc, dTerm;
   logic  rClr, rInc, rTerm;
   logic  stepRpt;
   logic [W-1:0] rTermVal;

   assign rTermVal = rptPhase ? RATE_TERM : DLY_TERM;

   hold_counter #(.W(W)) uDcnt (
      .clock   (clock),
      .rst     (rst),
      .clr     (dClr),
      .load    (dLoad),
      .en      (dInc),
      .loadVal (ONE),
      .termVal (D_TERM),
      .atTerm  (dTerm)
   );

   hold_counter #(.W(W)) uRcnt (
      .clock   (clock),
      .rst     (rst),
      .clr     (rClr),
      .load    (1'b0),
      .en      (rInc),
      .loadVal ('0),
      .termVal (rTermVal),
      .atTerm  (rTerm)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state        <= IDLE;
         rptPhase     <= 1'b0;
         level        <= 1'b0;
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
         repeatPulse  <= 1'b0;
         longHold     <= 1'b0;
      end else begin
         state        <= stateN;
         rptPhase     <= phaseN;
         level        <= levelN;
         pressPulse   <= pressN;
         releasePulse <= releaseN;
         repeatPulse  <= repeatN;
         longHold     <= longHoldN;
      end
   end

   always_comb begin
      stateN    = state;
      phaseN    = rptPhase;
      levelN    = level;
      pressN    = 1'b0;
      releaseN  = 1'b0;
      repeatN   = 1'b0;
      longHoldN = longHold;
      dClr      = 1'b0;
      dLoad     = 1'b0;
      dInc      = 1'b0;
      rClr      = 1'b0;
      rInc      = 1'b0;
      stepRpt   = 1'b0;

      unique case (state)
         IDLE: begin
            levelN = 1'b0;
            if (syncIn) begin
               stateN = PRESS_WAIT;
               dLoad  = 1'b1;
            end
         end
         PRESS_WAIT: begin
            if (!syncIn) begin
               stateN = IDLE;
               dClr   = 1'b1;
            end else if (dTerm) begin
               stateN = HELD;
               levelN = 1'b1;
               pressN = 1'b1;
               phaseN = 1'b0;
               rClr   = 1'b1;
               dClr   = 1'b1;
            end else begin
               dInc = 1'b1;
            end
         end
         HELD: begin
            if (!syncIn) begin
               stateN = RELEASE_WAIT;
               dLoad  = 1'b1;
            end else begin
               stepRpt = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (syncIn) begin
               // Bounce back: repeat timing resumes this cycle.
               stateN  = HELD;
               dClr    = 1'b1;
               stepRpt = 1'b1;
            end else if (dTerm) begin
               stateN    = IDLE;
               levelN    = 1'b0;
               releaseN  = 1'b1;
               longHoldN = 1'b0;
               phaseN    = 1'b0;
               dClr      = 1'b1;
            end else begin
               dInc = 1'b1;
            end
         end
         default: begin
            stateN = IDLE;
         end
      endcase

      if (stepRpt) begin
         if (!repeatEn) begin
            rClr = 1'b1;
         end else if (rTerm) begin
            repeatN   = 1'b1;
            rClr      = 1'b1;
            phaseN    = 1'b1;
            longHoldN = 1'b1;
         end else begin
            rInc = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_debounce_repeat.sv
// Bench for debounce_repeat with small debounce/repeat parameters.
// Expected strobe cycles are queued per scenario and matched on output.
module tb_debounce_repeat;

   logic clock = 1'b0;
   logic rst;
   logic syncIn;
   logic repeatEn;
   logic level;
   logic pressPulse;
   logic releasePulse;
   logic repeatPulse;
   logic longHold;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int pressQ[$];
   int relQ[$];
   int rptQ[$];

   debounce_repeat #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .syncIn       (syncIn),
      .repeatEn     (repeatEn),
      .level        (level),
      .pressPulse   (pressPulse),
      .releasePulse (releasePulse),
      .repeatPulse  (repeatPulse),
      .longHold     (longHold)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every strobe must match the next queued cycle.
   always @(negedge clock) begin
      int e;
      if (pressPulse | releasePulse | repeatPulse) begin
         checks++;
         if (int'(pressPulse) + int'(releasePulse)
             + int'(repeatPulse) > 1) begin
            errors++;
            $display("FAIL exclusive cyc=%0d got %b%b%b",
               cyc, pressPulse, releasePulse, repeatPulse);
         end
      end
      if (pressPulse) begin
         checks++;
         if (pressQ.size() == 0) begin
            errors++;
            $display("FAIL press got cyc=%0d required none", cyc);
         end else begin
            e = pressQ.pop_front();
            if (cyc !== e) begin
               errors++;
               $display("FAIL press got cyc=%0d required %0d", cyc, e);
            end
         end
      end
      if (releasePulse) begin
         checks++;
         if (relQ.size() == 0) begin
            errors++;
            $display("FAIL release got cyc=%0d required none", cyc);
         end else begin
            e = relQ.pop_front();
            if (cyc !== e) begin
               errors++;
               $display("FAIL release got cyc=%0d required %0d", cyc, e);
            end
         end
      end
      if (repeatPulse) begin
         checks++;
         if (rptQ.size() == 0) begin
            errors++;
            $display("FAIL repeat got cyc=%0d required none", cyc);
         end else begin
            e = rptQ.pop_front();
            if (cyc !== e) begin
               errors++;
               $display("FAIL repeat got cyc=%0d required %0d", cyc, e);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      syncIn = 1'b1;
      repeatEn = 1'b0;
      tick(2);
      checks++;
      if ({level, pressPulse, releasePulse, repeatPulse, longHold}
          !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b required 00000",
            {level, pressPulse, releasePulse, repeatPulse, longHold});
      end
      rst = 1'b0;
      pressQ.push_back(cyc + 4);
      tick(3);
      checks++;
      if (level !== 1'b0) begin
         errors++;
         $display("FAIL reset_early_level got %b required 0", level);
      end
      tick(1);
      checks++;
      if (level !== 1'b1) begin
         errors++;
         $display("FAIL reset_press_level got %b required 1", level);
      end
      tick(2);
      syncIn = 1'b0;
      relQ.push_back(cyc + 4);
      tick(3);
      checks++;
      if (level !== 1'b1) begin
         errors++;
         $display("FAIL reset_rel_early got %b required 1", level);
      end
      tick(1);
      checks++;
      if (level !== 1'b0) begin
         errors++;
         $display("FAIL reset_rel_level got %b required 0", level);
      end
      tick(2);
      checks++;
      if (pressQ.size() + relQ.size() + rptQ.size() != 0) begin
         errors++;
         $display("FAIL reset_pending got %0d required 0",
            pressQ.size() + relQ.size() + rptQ.size());
      end
   endtask

   task automatic test_glitch();
      syncIn = 1'b1;
      tick(3);
      syncIn = 1'b0;
      tick(4);
      checks++;
      if (level !== 1'b0) begin
         errors++;
         $display("FAIL glitch_level got %b required 0", level);
      end
      syncIn = 1'b1;
      pressQ.push_back(cyc + 4);
      tick(6);
      checks++;
      if (level !== 1'b1) begin
         errors++;
         $display("FAIL glitch_press got %b required 1", level);
      end
      syncIn = 1'b0;
      relQ.push_back(cyc + 4);
      tick(6);
      checks++;
      if (pressQ.size() + relQ.size() + rptQ.size() != 0) begin
         errors++;
         $display("FAIL glitch_pending got %0d required 0",
            pressQ.size() + relQ.size() + rptQ.size());
      end
   endtask

   task automatic test_repeat();
      int p;
      repeatEn = 1'b1;
      syncIn = 1'b1;
      p = cyc + 4;
      pressQ.push_back(p);
      rptQ.push_back(p + 10);
      rptQ.push_back(p + 13);
      rptQ.push_back(p + 16);
      rptQ.push_back(p + 19);
      tick(13);
      checks++;
      if (longHold !== 1'b0) begin
         errors++;
         $display("FAIL repeat_lh_before got %b required 0", longHold);
      end
      tick(1);
      checks++;
      if (longHold !== 1'b1) begin
         errors++;
         $display("FAIL repeat_lh_first got %b required 1", longHold);
      end
      tick(10);
      syncIn = 1'b0;
      relQ.push_back(cyc + 4);
      tick(4);
      checks++;
      if ({level, longHold} !== 2'b00) begin
         errors++;
         $display("FAIL repeat_release got %b required 00",
            {level, longHold});
      end
      tick(2);
      checks++;
      if (pressQ.size() + relQ.size() + rptQ.size() != 0) begin
         errors++;
         $display("FAIL repeat_pending got %0d required 0",
            pressQ.size() + relQ.size() + rptQ.size());
      end
   endtask

   task automatic test_hold_glitch();
      int p;
      syncIn = 1'b1;
      p = cyc + 4;
      pressQ.push_back(p);
      rptQ.push_back(p + 12);
      rptQ.push_back(p + 15);
      tick(7);
      syncIn = 1'b0;
      tick(2);
      checks++;
      if (level !== 1'b1) begin
         errors++;
         $display("FAIL hglitch_level got %b required 1", level);
      end
      syncIn = 1'b1;
      tick(1);
      checks++;
      if (level !== 1'b1) begin
         errors++;
         $display("FAIL hglitch_back got %b required 1", level);
      end
      tick(9);
      syncIn = 1'b0;
      relQ.push_back(cyc + 4);
      tick(6);
      checks++;
      if (pressQ.size() + relQ.size() + rptQ.size() != 0) begin
         errors++;
         $display("FAIL hglitch_pending got %0d required 0",
            pressQ.size() + relQ.size() + rptQ.size());
      end
   endtask

   task automatic test_restart();
      int p;
      syncIn = 1'b1;
      p = cyc + 4;
      pressQ.push_back(p);
      rptQ.push_back(p + 10);
      tick(4);
      checks++;
      if (longHold !== 1'b0) begin
         errors++;
         $display("FAIL restart_lh got %b required 0", longHold);
      end
      tick(10);
      checks++;
      if (longHold !== 1'b1) begin
         errors++;
         $display("FAIL restart_lh_rpt got %b required 1", longHold);
      end
      syncIn = 1'b0;
      relQ.push_back(cyc + 4);
      tick(6);
      checks++;
      if (pressQ.size() + relQ.size() + rptQ.size() != 0) begin
         errors++;
         $display("FAIL restart_pending got %0d required 0",
            pressQ.size() + relQ.size() + rptQ.size());
      end
   endtask

   task automatic test_no_repeat_rst();
      repeatEn = 1'b0;
      syncIn = 1'b1;
      pressQ.push_back(cyc + 4);
      tick(34);
      checks++;
      if ({level, longHold} !== 2'b10) begin
         errors++;
         $display("FAIL norpt_hold got %b required 10",
            {level, longHold});
      end
      repeatEn = 1'b1;
      rptQ.push_back(cyc + 10);
      tick(11);
      checks++;
      if (longHold !== 1'b1) begin
         errors++;
         $display("FAIL norpt_reen got %b required 1", longHold);
      end
      rst = 1'b1;
      syncIn = 1'b0;
      tick(1);
      checks++;
      if ({level, pressPulse, releasePulse, repeatPulse, longHold}
          !== 5'b0) begin
         errors++;
         $display("FAIL midrst_outs got %b required 00000",
            {level, pressPulse, releasePulse, repeatPulse, longHold});
      end
      rst = 1'b0;
      repeatEn = 1'b0;
      tick(6);
      checks++;
      if ({level, longHold} !== 2'b00) begin
         errors++;
         $display("FAIL postrst_outs got %b required 00",
            {level, longHold});
      end
      checks++;
      if (pressQ.size() + relQ.size() + rptQ.size() != 0) begin
         errors++;
         $display("FAIL norpt_pending got %0d required 0",
            pressQ.size() + relQ.size() + rptQ.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      syncIn = 1'b0;
      repeatEn = 1'b0;
      tick(1);
      test_reset();
      test_glitch();
      test_repeat();
      test_hold_glitch();
      test_restart();
      test_no_repeat_rst();
      $display("Simulation finished: %0d checks, %0d errors",
         checks, errors);
      $finish;
   end

endmodule
